// File: rtl/delay_requester_if.sv
// Request/handshake bundle between the game FSM, the delay requester and
// the tick Counter. The master side is the delay requester itself.
interface delay_requester_if #(
  parameter int WIDTH = 12
);
  logic             i_Start;
  logic [WIDTH-1:0] i_Delay;
  logic             i_Abort;
  logic [WIDTH-1:0] i_Count;
  logic             i_TwoSec;
  logic             o_RstCounter;
  logic             o_ActCounter;
  logic             o_Busy;
  logic             o_Done;
  logic             o_Err;

  modport master (
    input  i_Start, i_Delay, i_Abort, i_Count, i_TwoSec,
    output o_RstCounter, o_ActCounter, o_Busy, o_Done, o_Err
  );

  modport slave (
    output i_Start, i_Delay, i_Abort, i_Count, i_TwoSec,
    input  o_RstCounter, o_ActCounter, o_Busy, o_Done, o_Err
  );
endinterface

// File: rtl/delay_requester.sv
// Timed-wait initiator: clears and runs the tick Counter, watches its count
// for completion, overshoot or stall, and reports done or a sticky error.
//
// state | meaning
// IDLE  | waiting for a request; o_Err holds its last value
// CLEAR | one cycle of counter clear
// COUNT | counter enabled, comparing count against the latched delay
// DONE  | one-cycle completion pulse
// ERR   | one cycle after overshoot or stall; o_Err latched
module delay_requester #(
  parameter int WIDTH     = 12,
  parameter int STALL_MAX = 4
) (
  input  logic                clk_2K,
  input  logic                i_Reset,
  delay_requester_if.master   bus
);

  localparam int STALL_W = $clog2(STALL_MAX + 1);
  localparam logic [WIDTH-1:0]   MaxCount   = '1;
  localparam logic [STALL_W-1:0] StallLimit = STALL_W'(STALL_MAX);

  typedef enum logic [2:0] {IDLE, CLEAR, COUNT, DONE, ERR} state_t;

  state_t             state, nextState;
  logic [WIDTH-1:0]   r_Delay, nextDelay;
  logic [WIDTH-1:0]   r_LastCount, nextLast;
  logic [STALL_W-1:0] r_Stall, nextStall, stallInc;
  logic               nextErr;

  // Next-state, datapath and sticky-error decisions.
  always_comb begin
    nextState = state;
    nextDelay = r_Delay;
    nextLast  = r_LastCount;
    nextStall = r_Stall;
    nextErr   = bus.o_Err;
    stallInc  = r_Stall + STALL_W'(1);
    case (state)
      IDLE: begin
        if (bus.i_Start && !bus.i_Abort) begin
          nextDelay = bus.i_Delay;
          nextErr   = 1'b0;
          nextState = (bus.i_Delay != '0) ? CLEAR : DONE;
        end
      end
      CLEAR: begin
        nextState = COUNT;
        nextStall = '0;
        nextLast  = '0;
      end
      COUNT: begin
        if (bus.i_Abort) begin
          nextState = IDLE;
        end else if (bus.i_Count == r_Delay) begin
          nextState = DONE;
        end else if (bus.i_TwoSec && (r_Delay != MaxCount)) begin
          nextState = ERR;
        end else if (bus.i_Count > r_Delay) begin
          nextState = ERR;
        end else if (bus.i_Count == r_LastCount) begin
          nextStall = stallInc;
          if (stallInc >= StallLimit) nextState = ERR;
        end else begin
          nextStall = '0;
          nextLast  = bus.i_Count;
        end
      end
      DONE:    nextState = IDLE;
      ERR:     nextState = IDLE;
      default: nextState = IDLE;
    endcase
    if (nextState == ERR) nextErr = 1'b1;
  end

  // State, datapath and Moore outputs registered from the next state.
  always_ff @(posedge clk_2K or negedge i_Reset) begin
    if (!i_Reset) begin
      state            <= IDLE;
      r_Delay          <= '0;
      r_LastCount      <= '0;
      r_Stall          <= '0;
      bus.o_RstCounter <= 1'b0;
      bus.o_ActCounter <= 1'b0;
      bus.o_Busy       <= 1'b0;
      bus.o_Done       <= 1'b0;
      bus.o_Err        <= 1'b0;
    end else begin
      state            <= nextState;
      r_Delay          <= nextDelay;
      r_LastCount      <= nextLast;
      r_Stall          <= nextStall;
      bus.o_RstCounter <= (nextState == CLEAR);
      bus.o_ActCounter <= (nextState == COUNT);
      bus.o_Busy       <= (nextState == CLEAR) || (nextState == COUNT) || (nextState == DONE);
      bus.o_Done       <= (nextState == DONE);
      bus.o_Err        <= nextErr;
    end
  end

endmodule

// File: tb/tb_delay_requester.sv
// Bench for delay_requester: a behavioural tick Counter (optionally frozen)
// plus a timeline model that predicts every output cycle by cycle.
module tb_delay_requester;

  localparam int WIDTH     = 12;
  localparam int STALL_MAX = 4;

  logic clk_2K = 1'b0;
  logic i_Reset;

  delay_requester_if #(.WIDTH(WIDTH)) bus();

  delay_requester #(.WIDTH(WIDTH), .STALL_MAX(STALL_MAX)) dut (
    .clk_2K  (clk_2K),
    .i_Reset (i_Reset),
    .bus     (bus)
  );

  // Free-running 2 kHz clock stand-in.
  always #5 clk_2K = ~clk_2K;

  logic [WIDTH-1:0] cnt;
  logic [WIDTH-1:0] cntOut;
  logic [WIDTH-1:0] freezeVal;
  logic             freezeEn;

  // Behavioural Counter: clear has priority, otherwise count while enabled.
  always @(posedge clk_2K) begin
    if (!i_Reset || bus.o_RstCounter) cnt <= '0;
    else if (bus.o_ActCounter)         cnt <= cnt + 1'b1;
  end

  assign cntOut     = freezeEn ? freezeVal : cnt;
  assign bus.i_Count  = cntOut;
  assign bus.i_TwoSec = &cntOut;

  int   nCompared   = 0;
  int   nMismatched = 0;
  logic expErr      = 1'b0;

  task automatic checkVal(input string tag, input logic [4:0] got, input logic [4:0] exp);
    nCompared++;
    if (got !== exp) begin
      nMismatched++;
      $display("FAIL %s: got {rst,act,busy,done,err}=%b, expected %b at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [4:0] outs();
    return {bus.o_RstCounter, bus.o_ActCounter, bus.o_Busy, bus.o_Done, bus.o_Err};
  endfunction

  task automatic idleCycles(input string tag, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk_2K);
      checkVal(tag, outs(), {4'b0000, expErr});
    end
  endtask

  // One request of D ticks. Sample k is taken after the k-th edge past the
  // start edge E (k=0 right after E). The wait ends at edge "term" with one
  // of: completion (kind 0), abort (kind 1) or error (kind 2).
  task automatic runWait(input string tag, input int D, input int abortA, input bit frz,
                         input int fVal, input bit extraStart, input int rstAt);
    int         term;
    int         kind;
    int         xs;
    logic [4:0] exp;
    logic       errNow;
    freezeEn  = frz;
    freezeVal = WIDTH'(fVal);
    if (D == 0) begin
      term = 0; kind = 0;
    end else begin
      term = D + 2; kind = 0;
      if (frz) begin
        kind = 2;
        if (fVal > D) term = 2;
        else          term = 1 + STALL_MAX + ((fVal != 0) ? 1 : 0);
      end
      if (abortA >= 2 && abortA <= term) begin
        term = abortA; kind = 1;
      end
    end
    xs = (extraStart && term >= 3) ? int'($urandom_range(1, term - 2)) : -1;
    bus.i_Start = 1'b1;
    bus.i_Delay = WIDTH'(D);
    bus.i_Abort = 1'b0;
    for (int k = 0; k <= term + 2; k++) begin
      @(negedge clk_2K);
      errNow = (kind == 2) && (k >= term);
      exp = {4'b0000, errNow};
      if (k < term) begin
        if (k == 0) exp[4] = 1'b1;
        else        exp[3] = 1'b1;
        exp[2] = 1'b1;
      end else if (k == term && kind == 0) begin
        exp[2] = 1'b1;
        exp[1] = 1'b1;
      end
      checkVal(tag, outs(), exp);
      if (k == rstAt) begin
        bus.i_Start = 1'b0;
        bus.i_Abort = 1'b0;
        #1 i_Reset = 1'b0;
        #1 checkVal({tag, "_rstAsync"}, outs(), 5'b00000);
        @(negedge clk_2K);
        checkVal({tag, "_rstHold"}, outs(), 5'b00000);
        i_Reset  = 1'b1;
        expErr   = 1'b0;
        freezeEn = 1'b0;
        return;
      end
      bus.i_Start = (k == xs);
      bus.i_Delay = WIDTH'($urandom);
      bus.i_Abort = (k == abortA - 1);
    end
    bus.i_Start = 1'b0;
    bus.i_Abort = 1'b0;
    freezeEn    = 1'b0;
    expErr      = (kind == 2);
  endtask

  // Hard stop if the run ever loses its way.
  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1);
  end

  initial begin
    int D;
    int mode;
    i_Reset     = 1'b0;
    bus.i_Start = 1'b0;
    bus.i_Delay = '0;
    bus.i_Abort = 1'b0;
    freezeEn    = 1'b0;
    freezeVal   = '0;
    #1 checkVal("rstInit", outs(), 5'b00000);
    repeat (3) @(negedge clk_2K);
    checkVal("rstHeld", outs(), 5'b00000);
    i_Reset = 1'b1;
    idleCycles("idle0", 2);

    runWait("d10", 10, 0, 0, 0, 0, -1);
    runWait("d0", 0, 0, 0, 0, 0, -1);
    runWait("stall3", 20, 0, 1, 3, 0, -1);
    idleCycles("errSticky", 3);

    bus.i_Start = 1'b1;
    bus.i_Abort = 1'b1;
    bus.i_Delay = WIDTH'(7);
    idleCycles("startAbort", 3);
    bus.i_Start = 1'b0;
    bus.i_Abort = 1'b0;

    runWait("errClear", 4, 0, 0, 0, 0, -1);
    runWait("stall0", 9, 0, 1, 0, 0, -1);
    runWait("overshoot", 20, 0, 1, 30, 0, -1);
    runWait("abort5", 100, 5, 0, 0, 0, -1);
    runWait("abortAtDone", 6, 8, 0, 0, 0, -1);
    runWait("xStart", 15, 0, 0, 0, 1, -1);
    runWait("rstMid", 200, 0, 0, 0, 0, 50);
    runWait("afterRst", 5, 0, 0, 0, 0, -1);
    runWait("dMax", 4095, 0, 0, 0, 0, -1);

    for (int it = 0; it < 40; it++) begin
      D    = int'($urandom_range(0, 40));
      mode = int'($urandom_range(0, 3));
      case (mode)
        1:       runWait("rndAbort", D, (D >= 1) ? int'($urandom_range(2, D + 2)) : 0, 0, 0, 0, -1);
        2:       runWait("rndFreeze", D, 0, (D >= 2), (D >= 2) ? int'($urandom_range(0, D - 1)) : 0, 0, -1);
        3:       runWait("rndXStart", D, 0, 0, 0, 1, -1);
        default: runWait("rndPlain", D, 0, 0, 0, 0, -1);
      endcase
      idleCycles("rndGap", int'($urandom_range(0, 2)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
